// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline (IF/MEM) and memory-macro signals of the shared memory port
//   slave  : arbiter view (takes requests and mem_rdata, drives grants, returns and the memory access)
//   master : pipeline/memory view (the opposite directions)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              stall_if;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W/8-1:0] dm_wstrb;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, stall_if, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, stall_if, dm_gnt, dm_rvalid, dm_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and load/store
//   clk, reset : clock and synchronous active-high reset
//   bus        : IF request/return, MEM request/return and memory-macro signals (slave view)
module mem_port_arbiter #(
  parameter int MEM_LAT         = 1,
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);
  typedef enum logic {PRI_DATA, PRI_IF} state_t;
  state_t             state_q, state_d;
  logic [3:0]         streak_q, streak_d;
  logic [MEM_LAT-1:0] tv_q, tv_d;
  logic [MEM_LAT-1:0] to_q, to_d;
  logic               if_gnt, dm_gnt, push_v;
  // Contention is resolved by the FSM; a lone requester always wins.
  assign if_gnt = !reset && bus.if_req && (!bus.dm_req || state_q == PRI_IF);
  assign dm_gnt = !reset && bus.dm_req && (!bus.if_req || state_q == PRI_DATA);
  assign push_v = dm_gnt ? !bus.dm_we : if_gnt;
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    if (!bus.if_req || if_gnt)
      streak_d = '0;
    else if (dm_gnt)
      streak_d = (streak_q == 4'hf) ? streak_q : streak_q + 4'd1;
    if (state_q == PRI_DATA)
      state_d = (dm_gnt && bus.if_req && streak_q == 4'(MAX_DATA_STREAK - 1)) ? PRI_IF : PRI_DATA;
    else
      state_d = (if_gnt || !bus.if_req) ? PRI_DATA : PRI_IF;
  end
  // Tag pipe: bit 0 is the newest issue, bit MEM_LAT-1 lines up with mem_rdata.
  if (MEM_LAT > 1) begin : g_sh
    assign tv_d = {tv_q[MEM_LAT-2:0], push_v};
    assign to_d = {to_q[MEM_LAT-2:0], dm_gnt};
  end else begin : g_one
    assign tv_d = push_v;
    assign to_d = dm_gnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= PRI_DATA;
      streak_q <= '0;
      tv_q     <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      tv_q     <= tv_d;
      to_q     <= to_d;
    end
  end
  assign bus.if_gnt    = if_gnt;
  assign bus.dm_gnt    = dm_gnt;
  assign bus.stall_if  = !reset && bus.if_req && !if_gnt;
  // Masking with reset keeps a tag that reaches the output during reset from returning.
  assign bus.if_rvalid = !reset && tv_q[MEM_LAT-1] && !to_q[MEM_LAT-1];
  assign bus.dm_rvalid = !reset && tv_q[MEM_LAT-1] && to_q[MEM_LAT-1];
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.dm_rdata  = bus.mem_rdata;
  assign bus.mem_en    = if_gnt || dm_gnt;
  assign bus.mem_we    = dm_gnt && bus.dm_we;
  assign bus.mem_addr  = dm_gnt ? bus.dm_addr : if_gnt ? bus.if_addr : '0;
  assign bus.mem_wdata = dm_gnt ? bus.dm_wdata : '0;
  assign bus.mem_wstrb = (dm_gnt && bus.dm_we) ? bus.dm_wstrb : (if_gnt || dm_gnt) ? '1 : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table plus hand sequences with a return scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();
  mem_port_arbiter #(.MEM_LAT(1), .MAX_DATA_STREAK(4)) u1 (.clk(clk), .reset(reset), .bus(b1));
  mem_port_arbiter #(.MEM_LAT(2), .MAX_DATA_STREAK(4)) u2 (.clk(clk), .reset(reset), .bus(b2));

  function automatic logic [31:0] mfn(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000);
  endfunction

  logic [31:0] a1, a2a, a2b;
  always_ff @(posedge clk) begin
    a1  <= b1.mem_addr;
    a2a <= b2.mem_addr;
    a2b <= a2a;
  end
  assign b1.mem_rdata = mfn(a1);
  assign b2.mem_rdata = mfn(a2b);

  int checks = 0;
  int passes = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask

  typedef struct packed { logic dm; logic [31:0] d; } ret_t;
  ret_t q1[$];
  always @(negedge clk) begin
    ret_t e;
    if (b1.if_rvalid || b1.dm_rvalid) begin
      if (q1.size() == 0) chk("rvalid unexpected", 64'({b1.if_rvalid, b1.dm_rvalid}), 64'd0);
      else begin
        e = q1.pop_front();
        chk("ret owner", 64'({b1.if_rvalid, b1.dm_rvalid}), e.dm ? 64'd1 : 64'd2);
        chk("ret data", 64'(e.dm ? b1.dm_rdata : b1.if_rdata), 64'(e.d));
      end
    end
  end

  task automatic step(input string n, input logic ir, input logic [31:0] ia, input logic dr,
                      input logic we, input logic [31:0] da, input logic [31:0] wd,
                      input logic [3:0] st, input logic eif, input logic edm);
    b1.if_req = ir; b1.if_addr = ia; b1.dm_req = dr; b1.dm_we = we;
    b1.dm_addr = da; b1.dm_wdata = wd; b1.dm_wstrb = st;
    @(negedge clk);
    chk({n, " ctl"}, 64'({b1.if_gnt, b1.dm_gnt, b1.stall_if, b1.mem_en, b1.mem_we}),
        64'({eif, edm, ir && !eif, eif || edm, edm && we}));
    if (eif || edm) begin
      chk({n, " addr"}, 64'(b1.mem_addr), 64'(edm ? da : ia));
      chk({n, " wstrb"}, 64'(b1.mem_wstrb), 64'((edm && we) ? st : 4'hf));
      if (edm && we) chk({n, " wdata"}, 64'(b1.mem_wdata), 64'(wd));
      else q1.push_back('{dm: edm, d: mfn(edm ? da : ia)});
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input string n);
    step(n, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0);
  endtask

  task automatic rst_chk(input string n);
    b1.if_req = 1'b1; b1.if_addr = 32'h44; b1.dm_req = 1'b1; b1.dm_we = 1'b1;
    b1.dm_addr = 32'h1_0044; b1.dm_wdata = 32'hDEAD_BEEF; b1.dm_wstrb = 4'hf;
    @(negedge clk);
    chk({n, " ctl"}, 64'({b1.if_gnt, b1.dm_gnt, b1.stall_if, b1.mem_en, b1.mem_we,
                          b1.if_rvalid, b1.dm_rvalid}), 64'd0);
    chk({n, " bus"}, {b1.mem_addr, b1.mem_wdata}, 64'd0);
    chk({n, " wstrb"}, 64'(b1.mem_wstrb), 64'd0);
    @(posedge clk); #1;
  endtask

  typedef struct { logic ir, dr, we; logic [3:0] st; logic eif, edm; } vec_t;
  vec_t tbl[17];

  initial begin
    tbl = '{
      '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b1, 4'hf, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0},
      '{1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1},
      '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0}
    };
    b2.if_req = 1'b0; b2.if_addr = '0; b2.dm_req = 1'b0; b2.dm_we = 1'b0;
    b2.dm_addr = '0; b2.dm_wdata = '0; b2.dm_wstrb = '0;
    @(posedge clk); #1;
    rst_chk("reset");
    reset = 1'b0;
    for (int i = 0; i < 17; i++)
      step($sformatf("v%0d", i), tbl[i].ir, 32'(32'h100 + 4 * i), tbl[i].dr, tbl[i].we,
           32'(32'h1_0000 + 4 * i), 32'(32'h11 * i), tbl[i].st, tbl[i].eif, tbl[i].edm);
    step("t1", 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    b1.if_req = 1'b0;
    @(negedge clk);
    chk("t1 rvalid", 64'({b1.if_rvalid, b1.dm_rvalid}), 64'd2);
    chk("t1 rdata", 64'(b1.if_rdata), 64'h0050_0093);
    @(posedge clk); #1;
    step("t2a", 1'b1, 32'h20, 1'b1, 1'b0, 32'h1_0004, 32'h0, 4'h0, 1'b0, 1'b1);
    step("t2b", 1'b1, 32'h20, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++)
      step($sformatf("t3c%0d", i), 1'b1, 32'h30, 1'b1, 1'b0, 32'h1_0008, 32'h0, 4'h0,
           i == 4, i != 4);
    step("t4", 1'b0, 32'h0, 1'b1, 1'b1, 32'h1_0000, 32'hAB, 4'b0001, 1'b0, 1'b1);
    b1.dm_req = 1'b0;
    @(negedge clk);
    chk("t4 no rvalid", 64'(b1.dm_rvalid), 64'd0);
    @(posedge clk); #1;
    idle("t4c");
    step("t6", 1'b0, 32'h0, 1'b1, 1'b0, 32'h1_0010, 32'h0, 4'h0, 1'b0, 1'b1);
    reset = 1'b1;
    q1.delete();
    rst_chk("t6rst");
    reset = 1'b0;
    for (int i = 0; i < 5; i++)
      step($sformatf("t6c%0d", i), 1'b1, 32'h50, 1'b1, 1'b0, 32'h1_0050, 32'h0, 4'h0,
           i == 4, i != 4);
    idle("t6d");
    idle("t6e");
    for (int k = 0; k < 6; k++) begin
      b2.if_req = (k == 0 || k == 2);
      b2.if_addr = (k == 0) ? 32'h40 : 32'h44;
      b2.dm_req = (k == 1);
      b2.dm_addr = 32'h1_0040;
      @(negedge clk);
      chk($sformatf("t5 gnt%0d", k), 64'({b2.if_gnt, b2.dm_gnt}),
          64'((k == 1) ? 2'b01 : (k == 0 || k == 2) ? 2'b10 : 2'b00));
      chk($sformatf("t5 rv%0d", k), 64'({b2.if_rvalid, b2.dm_rvalid}),
          64'((k == 3) ? 2'b01 : (k == 2 || k == 4) ? 2'b10 : 2'b00));
      if (k >= 2 && k <= 4)
        chk($sformatf("t5 data%0d", k), 64'((k == 3) ? b2.dm_rdata : b2.if_rdata),
            64'(mfn((k == 2) ? 32'h40 : (k == 3) ? 32'h1_0040 : 32'h44)));
      @(posedge clk); #1;
    end
    chk("scoreboard drained", 64'(q1.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
